// File: rtl/id_ex_reg_if.sv
// Decode-to-execute bundle: decoded instruction in, registered EX copy out,
// plus stall/flush control and the performance counters.
interface id_ex_reg_if #(
    parameter int WORD_LEN = 32,
    parameter int CNT_W    = 16
);
    logic                freeze;
    logic                flush;
    logic                id_valid;
    logic [WORD_LEN-1:0] id_pc;
    logic [WORD_LEN-1:0] id_r1;
    logic [WORD_LEN-1:0] id_r2;
    logic [4:0]          id_src1;
    logic [4:0]          id_src2;
    logic [4:0]          id_dest;
    logic [WORD_LEN-1:0] id_imm;
    logic [3:0]          id_exe_cmd;
    logic                id_mem_read;
    logic                id_mem_write;
    logic                id_wb_en;
    logic                id_is_imm;
    logic                id_uses_src2;

    logic                ex_valid;
    logic [WORD_LEN-1:0] ex_pc;
    logic [WORD_LEN-1:0] ex_r1;
    logic [WORD_LEN-1:0] ex_r2;
    logic [WORD_LEN-1:0] ex_imm;
    logic [4:0]          ex_src1;
    logic [4:0]          ex_src2;
    logic [4:0]          ex_dest;
    logic [3:0]          ex_exe_cmd;
    logic                ex_mem_read;
    logic                ex_mem_write;
    logic                ex_wb_en;
    logic                ex_is_imm;
    logic                load_use_stall;
    logic [CNT_W-1:0]    bubble_cnt;
    logic [CNT_W-1:0]    flush_cnt;

    modport master (
        output freeze, flush, id_valid, id_pc, id_r1, id_r2, id_src1, id_src2,
               id_dest, id_imm, id_exe_cmd, id_mem_read, id_mem_write,
               id_wb_en, id_is_imm, id_uses_src2,
        input  ex_valid, ex_pc, ex_r1, ex_r2, ex_imm, ex_src1, ex_src2,
               ex_dest, ex_exe_cmd, ex_mem_read, ex_mem_write, ex_wb_en,
               ex_is_imm, load_use_stall, bubble_cnt, flush_cnt
    );

    modport slave (
        input  freeze, flush, id_valid, id_pc, id_r1, id_r2, id_src1, id_src2,
               id_dest, id_imm, id_exe_cmd, id_mem_read, id_mem_write,
               id_wb_en, id_is_imm, id_uses_src2,
        output ex_valid, ex_pc, ex_r1, ex_r2, ex_imm, ex_src1, ex_src2,
               ex_dest, ex_exe_cmd, ex_mem_read, ex_mem_write, ex_wb_en,
               ex_is_imm, load_use_stall, bubble_cnt, flush_cnt
    );
endinterface

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with flush, freeze, load-use bubble insertion and
// saturating bubble/flush counters.
module id_ex_reg #(
    parameter int WORD_LEN = 32,
    parameter int CNT_W    = 16
) (
    input logic        clk,
    input logic        rst,
    id_ex_reg_if.slave bus
);
    typedef struct packed {
        logic                valid;
        logic [WORD_LEN-1:0] pc;
        logic [WORD_LEN-1:0] r1;
        logic [WORD_LEN-1:0] r2;
        logic [WORD_LEN-1:0] imm;
        logic [4:0]          src1;
        logic [4:0]          src2;
        logic [4:0]          dest;
        logic [3:0]          exe_cmd;
        logic                mem_read;
        logic                mem_write;
        logic                wb_en;
        logic                is_imm;
    } ex_t;

    ex_t              ex_q, ex_d, capture;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             src1_hit, src2_hit, load_use;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    // A load to $0 never stalls; an immediate-form instruction ignores src2.
    assign src1_hit = (bus.id_src1 == ex_q.dest);
    assign src2_hit = bus.id_uses_src2 & ~bus.id_is_imm & (bus.id_src2 == ex_q.dest);
    assign load_use = ex_q.valid & ex_q.mem_read & ex_q.wb_en & (ex_q.dest != 5'd0)
                    & bus.id_valid & (src1_hit | src2_hit);

    always_comb begin
        capture           = '0;
        capture.valid     = bus.id_valid;
        capture.pc        = bus.id_pc;
        capture.r1        = bus.id_r1;
        capture.r2        = bus.id_r2;
        capture.imm       = bus.id_imm;
        capture.src1      = bus.id_src1;
        capture.src2      = bus.id_src2;
        capture.dest      = bus.id_dest;
        // An empty decode slot must not carry stray side effects into EX.
        capture.exe_cmd   = bus.id_valid ? bus.id_exe_cmd : 4'd0;
        capture.mem_read  = bus.id_valid & bus.id_mem_read;
        capture.mem_write = bus.id_valid & bus.id_mem_write;
        capture.wb_en     = bus.id_valid & bus.id_wb_en;
        capture.is_imm    = bus.id_valid & bus.id_is_imm;
    end

    always_comb begin
        ex_d         = ex_q;
        bubble_cnt_d = bubble_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        if (bus.flush) begin
            ex_d = '0;
            if (bus.id_valid) begin
                flush_cnt_d = sat_inc(flush_cnt_q);
            end
        end else if (bus.freeze) begin
            ex_d = ex_q;
        end else if (load_use) begin
            ex_d         = '0;
            bubble_cnt_d = sat_inc(bubble_cnt_q);
        end else begin
            ex_d = capture;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q         <= '0;
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            ex_q         <= ex_d;
            bubble_cnt_q <= bubble_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign bus.ex_valid       = ex_q.valid;
    assign bus.ex_pc          = ex_q.pc;
    assign bus.ex_r1          = ex_q.r1;
    assign bus.ex_r2          = ex_q.r2;
    assign bus.ex_imm         = ex_q.imm;
    assign bus.ex_src1        = ex_q.src1;
    assign bus.ex_src2        = ex_q.src2;
    assign bus.ex_dest        = ex_q.dest;
    assign bus.ex_exe_cmd     = ex_q.exe_cmd;
    assign bus.ex_mem_read    = ex_q.mem_read;
    assign bus.ex_mem_write   = ex_q.mem_write;
    assign bus.ex_wb_en       = ex_q.wb_en;
    assign bus.ex_is_imm      = ex_q.is_imm;
    assign bus.load_use_stall = load_use;
    assign bus.bubble_cnt     = bubble_cnt_q;
    assign bus.flush_cnt      = flush_cnt_q;
endmodule
